bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
Iterative, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble). It processes one binary bit per clock and supports arbitrary input width and digit count. It has a start/busy/done handshake, overflow detection and a significant-digit count for display blanking. It sits between the watch counters/arithmetic and the 7-segment display drivers, and replaces the fixed 6-bit, 2-digit converter for wider fields such as stopwatch centiseconds, day-of-year and alarm totals.

Parameters:
BIN_WIDTH, 16, width of binary input (>=2)
DIGITS, 5, number of BCD digits produced (>=1)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request conversion; sampled only in IDLE or DONE
binary  input  BIN_WIDTH  value to convert; captured on the accepted start edge only
busy  output  1  high while a conversion is in progress (state SHIFT)
done  output  1  one-cycle pulse when bcd/overflow/num_digits update
bcd  output  4*DIGITS  result; digit k at bits [4k+3:4k], k=0 least significant; held until next done
overflow  output  1  binary >= 10**DIGITS; held with bcd
num_digits  output  $clog2(DIGITS+1)  significant digits in bcd, range 1..DIGITS (value 0 gives 1); held with bcd

Behaviour:
- Reset (asynchronous assert, synchronous-safe release): state=IDLE; busy=0, done=0, bcd=0, overflow=0, num_digits=1; internal shift/working registers=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: start=1 -> load bin_sr<=binary, bcd_work<=0, ovf_work<=0, bit count<=BIN_WIDTH, go to SHIFT. Otherwise stay.
- SHIFT (busy=1), each cycle:
  - Every digit of bcd_work >=5 gets +3 (combinational, all digits in parallel).
  - Then {bcd_work, bin_sr} shifts left by 1.
  - ovf_work |= bit shifted out of the top of bcd_work.
  - Decrement count. Once BIN_WIDTH shifts are done -> DONE.
- start during SHIFT is ignored. binary changes after capture have no effect.
- DONE (one cycle):
  - Output registers bcd<=bcd_work, overflow<=ovf_work, num_digits<=index of highest nonzero digit +1 (1 if all zero); done=1.
  - start=1 in this cycle -> load a new conversion and go to SHIFT (back-to-back); else go to IDLE.
- Latency: start sampled at edge 0, done high after edge BIN_WIDTH+1, outputs valid from that same edge. Back-to-back throughput is one result per BIN_WIDTH+1 cycles.
- Overflow: bcd = binary mod 10**DIGITS (natural truncation of the top carry); overflow=1; num_digits counts the truncated digits.
- Each digit is always 0..9; no code above 9 ever appears on bcd.
- reset_n asserted mid-conversion: aborts immediately to reset values, no done pulse.
- Outputs change only on a done cycle or on reset.

Decomposition:
- Package bin2bcd_pkg:
  - state enum {IDLE, SHIFT, DONE};
  - constant function digits_needed(width) = ceil(width*log10(2)), for callers sizing DIGITS;
  - constant function cnt_width(width) for the bit counter.
- Sub-module bcd_digit_adj: 4-bit in/out, adds 3 when input >=5. Instantiated DIGITS times via generate.

Test Plan:
- BIN_WIDTH=6, DIGITS=2, exhaustive 0..63 -> bcd equals decimal (e.g. 63 -> 0x63), overflow=0, done exactly 7 cycles after start each time.
- Defaults, binary=0 -> bcd=0x00000, num_digits=1. binary=65535 -> bcd=0x65535, num_digits=5. binary=9999 -> 0x09999, num_digits=4. done 17 cycles after start, single-cycle pulse.
- BIN_WIDTH=16, DIGITS=3, binary=1234 -> bcd=0x234, overflow=1, num_digits=3. Then binary=999 -> 0x999, overflow=0.
- Start 300, then pulse start with binary=777 at cycle 5 of SHIFT and change binary mid-run -> result 0x00300, busy continuous, only one done.
- Start held high -> back-to-back conversions 42 then 43: done pulses 17 cycles apart, busy low only in DONE cycles, results 0x00042 and 0x00043.
- Drop reset_n at cycle 8 of a conversion of 12345 -> all outputs return to reset values asynchronously, no done. After release, start 12345 -> 0x12345.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and sizing helpers for the iterative binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  // ceil(width * log10(2)); log10(2) approximated as 0.30103
  function automatic int digits_needed(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more before the shift.
module bcd_digit_adj (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one binary bit per clock,
// with start/busy/done handshake, overflow flag and significant-digit count.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 5
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [BIN_WIDTH-1:0]         binary,
  output logic                         busy,
  output logic                         done,
  output logic [4*DIGITS-1:0]          bcd,
  output logic                         overflow,
  output logic [$clog2(DIGITS+1)-1:0]  num_digits
);

  localparam int CW  = cnt_width(BIN_WIDTH);
  localparam int NDW = $clog2(DIGITS + 1);
  localparam int BW  = 4 * DIGITS;

  state_e               state_q, state_d;
  logic [BIN_WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0]        work_q, work_d;
  logic                 ovfw_q, ovfw_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;
  logic [NDW-1:0]       nd_q, nd_d;
  logic                 done_q, done_d;

  logic [BW-1:0]        adj;
  logic [NDW-1:0]       nd_calc;
  logic                 load;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit_adj u_adj (
      .d_i (work_q[4*g +: 4]),
      .d_o (adj[4*g +: 4])
    );
  end

  always_comb begin
    nd_calc = NDW'(1);
    for (int k = 1; k < DIGITS; k++)
      if (work_q[4*k +: 4] != 4'd0) nd_calc = NDW'(k + 1);
  end

  // A new request is accepted in IDLE and in DONE (back-to-back), never mid-shift
  assign load = start && (state_q != SHIFT);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    work_d  = work_q;
    ovfw_d  = ovfw_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    nd_d    = nd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: ;
      SHIFT: begin
        // Top carry is dropped from the result and only recorded as overflow
        work_d = {adj[BW-2:0], sr_q[BIN_WIDTH-1]};
        sr_d   = {sr_q[BIN_WIDTH-2:0], 1'b0};
        ovfw_d = ovfw_q | adj[BW-1];
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        bcd_d   = work_q;
        ovf_d   = ovfw_q;
        nd_d    = nd_calc;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = SHIFT;
      sr_d    = binary;
      work_d  = '0;
      ovfw_d  = 1'b0;
      cnt_d   = CW'(BIN_WIDTH);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      work_q  <= '0;
      ovfw_q  <= 1'b0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      nd_q    <= NDW'(1);
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      work_q  <= work_d;
      ovfw_q  <= ovfw_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      nd_q    <= nd_d;
      done_q  <= done_d;
    end
  end

  assign busy       = (state_q == SHIFT);
  assign done       = done_q;
  assign bcd        = bcd_q;
  assign overflow   = ovf_q;
  assign num_digits = nd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: three configurations (6/2, 16/5, 16/3) on one clock and reset.
module tb_bin2bcd_seq;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic        start_a, busy_a, done_a, ovf_a;
  logic [5:0]  bin_a;
  logic [7:0]  bcd_a;
  logic [1:0]  nd_a;

  logic        start_b, busy_b, done_b, ovf_b;
  logic [15:0] bin_b;
  logic [19:0] bcd_b;
  logic [2:0]  nd_b;

  logic        start_c, busy_c, done_c, ovf_c;
  logic [15:0] bin_c;
  logic [11:0] bcd_c;
  logic [1:0]  nd_c;

  bin2bcd_seq #(.BIN_WIDTH(6), .DIGITS(2)) u_a (
    .clock(clock), .reset_n(reset_n), .start(start_a), .binary(bin_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a), .num_digits(nd_a));

  bin2bcd_seq #(.BIN_WIDTH(16), .DIGITS(5)) u_b (
    .clock(clock), .reset_n(reset_n), .start(start_b), .binary(bin_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b), .num_digits(nd_b));

  bin2bcd_seq #(.BIN_WIDTH(16), .DIGITS(3)) u_c (
    .clock(clock), .reset_n(reset_n), .start(start_c), .binary(bin_c),
    .busy(busy_c), .done(done_c), .bcd(bcd_c), .overflow(ovf_c), .num_digits(nd_c));

  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic conv_a(input int v);
    int n;
    logic [7:0] eb;
    eb = 8'(((v / 10) << 4) | (v % 10));
    bin_a = 6'(v); start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (done_a) begin n = i; break; end
    end
    chk($sformatf("a_lat_%0d", v), n, 7);
    chk($sformatf("a_bcd_%0d", v), bcd_a, eb);
    chk($sformatf("a_ovf_%0d", v), ovf_a, 0);
    chk($sformatf("a_nd_%0d", v), nd_a, (v >= 10) ? 2 : 1);
    tick();
    chk($sformatf("a_pulse_%0d", v), done_a, 0);
  endtask

  task automatic conv_b(input int v, input logic [19:0] eb, input int end_nd);
    int n;
    bin_b = 16'(v); start_b = 1'b1; tick(); start_b = 1'b0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done_b) begin n = i; break; end
    end
    chk($sformatf("b_lat_%0d", v), n, 17);
    chk($sformatf("b_bcd_%0d", v), bcd_b, eb);
    chk($sformatf("b_ovf_%0d", v), ovf_b, 0);
    chk($sformatf("b_nd_%0d", v), nd_b, end_nd);
    tick();
    chk($sformatf("b_pulse_%0d", v), done_b, 0);
  endtask

  task automatic conv_c(input int v, input logic [11:0] eb, input logic eo, input int end_nd);
    int n;
    bin_c = 16'(v); start_c = 1'b1; tick(); start_c = 1'b0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done_c) begin n = i; break; end
    end
    chk($sformatf("c_lat_%0d", v), n, 17);
    chk($sformatf("c_bcd_%0d", v), bcd_c, eb);
    chk($sformatf("c_ovf_%0d", v), ovf_c, eo);
    chk($sformatf("c_nd_%0d", v), nd_c, end_nd);
    tick();
  endtask

  initial begin
    int n, dn, bb;
    reset_n = 1'b0;
    start_a = 0; start_b = 0; start_c = 0;
    bin_a = 0; bin_b = 0; bin_c = 0;
    #12;
    chk("rst_busy", busy_b, 0);
    chk("rst_done", done_b, 0);
    chk("rst_bcd", bcd_b, 0);
    chk("rst_ovf", ovf_b, 0);
    chk("rst_nd_b", nd_b, 1);
    chk("rst_nd_a", nd_a, 1);
    reset_n = 1'b1;
    tick();

    for (int v = 0; v < 64; v++) conv_a(v);

    conv_b(0,     20'h00000, 1);
    conv_b(65535, 20'h65535, 5);
    conv_b(9999,  20'h09999, 4);

    conv_c(1234, 12'h234, 1'b1, 3);
    conv_c(999,  12'h999, 1'b0, 3);
    conv_c(1000, 12'h000, 1'b1, 1);

    // start and binary changes during SHIFT must not disturb the running conversion
    bin_b = 16'd300; start_b = 1'b1; tick(); start_b = 1'b0;
    bb = busy_b ? 0 : 1;
    dn = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 5) begin start_b = 1'b1; bin_b = 16'd777; end
      if (i == 6) begin start_b = 1'b0; bin_b = 16'd12345; end
      if (i <= 15 && !busy_b) bb++;
      if (done_b) begin
        dn++;
        if (dn == 1) begin
          chk("mid_lat", i, 17);
          chk("mid_bcd", bcd_b, 20'h00300);
        end
      end
    end
    chk("mid_busy", bb, 0);
    chk("mid_done_cnt", dn, 1);

    // start held high: back-to-back 42 then 43
    bin_b = 16'd42; start_b = 1'b1; tick(); bin_b = 16'd43;
    dn = 0; bb = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 16 || i == 33) chk($sformatf("b2b_busy_low_%0d", i), busy_b, 0);
      else if (i <= 33 && !busy_b) bb++;
      if (done_b) dn++;
      if (i == 17) begin
        chk("b2b_done1", done_b, 1);
        chk("b2b_bcd1", bcd_b, 20'h00042);
        start_b = 1'b0;
      end
      if (i == 34) begin
        chk("b2b_done2", done_b, 1);
        chk("b2b_bcd2", bcd_b, 20'h00043);
      end
    end
    chk("b2b_busy_high", bb, 0);
    chk("b2b_done_cnt", dn, 2);

    // asynchronous reset in the middle of a conversion
    bin_b = 16'd12345; start_b = 1'b1; tick(); start_b = 1'b0;
    repeat (8) tick();
    chk("ar_busy_pre", busy_b, 1);
    reset_n = 1'b0;
    #1;
    chk("ar_busy", busy_b, 0);
    chk("ar_done", done_b, 0);
    chk("ar_bcd", bcd_b, 0);
    chk("ar_nd", nd_b, 1);
    chk("ar_bcd_a", bcd_a, 0);
    chk("ar_ovf_c", ovf_c, 0);
    dn = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 2) reset_n = 1'b1;
      if (done_b) dn++;
    end
    chk("ar_no_done", dn, 0);
    conv_b(12345, 20'h12345, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
